// File: rtl/fifo_spi_drain.sv
// fifo_spi_drain: pops bytes from the audio FIFO and shifts them MSB-first to the decoder SDI port.
//   clk, rst       system clock, asynchronous active-high reset
//   enable         permits new bursts and frames
//   fifo_empty     FIFO empty flag
//   fifo_data      FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en     single-cycle FIFO pop strobe
//   dreq           decoder ready, asynchronous, synchronised internally
//   sck, sdi       mode-0 serial clock (idle low) and serial data
//   xdcs           data chip-select, active low
//   busy           high whenever the engine is not idle
module fifo_spi_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4,
   parameter int BURST_LEN  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   input  logic                  dreq,
   output logic                  sck,
   output logic                  sdi,
   output logic                  xdcs,
   output logic                  busy
);
   localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam int BC_W  = $clog2(BURST_LEN + 1);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BC_W-1:0]  BURST_MX = BC_W'(BURST_LEN);

   typedef enum logic [2:0] {IDLE, RD, LOAD, SHIFT, GAP} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d, sh_nx;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BC_W-1:0]       burst_q, burst_d;
   logic                  sck_q, sck_d, sdi_q, sdi_d, xdcs_q, xdcs_d;
   logic                  dreq_m_q, dreq_s_q;
   logic                  div_end, frame_done, more;

   assign div_end    = div_q == DIV_MAX;
   // last falling edge of the frame: high phase ends on the final bit
   assign frame_done = state_q == SHIFT && div_end && sck_q && bit_q == BIT_LAST;
   // room for another frame in this grant once the current one is counted
   assign more       = (burst_q + BC_W'(1)) < BURST_MX;
   assign sh_nx      = sh_q << 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         burst_q  <= '0;
         sck_q    <= 1'b0;
         sdi_q    <= 1'b0;
         xdcs_q   <= 1'b1;
         dreq_m_q <= 1'b0;
         dreq_s_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         burst_q  <= burst_d;
         sck_q    <= sck_d;
         sdi_q    <= sdi_d;
         xdcs_q   <= xdcs_d;
         dreq_m_q <= dreq;
         dreq_s_q <= dreq_m_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable && dreq_s_q && !fifo_empty) state_d = RD;
         RD:      state_d = LOAD;
         LOAD:    state_d = SHIFT;
         SHIFT:   if (frame_done) state_d = (more && enable && !fifo_empty) ? RD : GAP;
         GAP:     if (div_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sh_d    = sh_q;
      bit_d   = bit_q;
      div_d   = div_q;
      burst_d = burst_q;
      sck_d   = sck_q;
      sdi_d   = sdi_q;
      xdcs_d  = xdcs_q;
      case (state_q)
         IDLE: begin
            div_d   = '0;
            bit_d   = '0;
            burst_d = '0;
         end
         LOAD: begin
            sh_d   = fifo_data;
            sdi_d  = fifo_data[DATA_WIDTH-1];
            xdcs_d = 1'b0;
            div_d  = '0;
            bit_d  = '0;
         end
         SHIFT: begin
            div_d = div_end ? '0 : div_q + DIV_W'(1);
            if (div_end) begin
               sck_d = !sck_q;
               if (sck_q) begin
                  sh_d  = sh_nx;
                  sdi_d = sh_nx[DATA_WIDTH-1];
                  bit_d = bit_q + BIT_W'(1);
               end
            end
            if (frame_done) begin
               bit_d   = '0;
               burst_d = burst_q + BC_W'(1);
            end
         end
         GAP: begin
            // sck held low one half-period after the last fall, then chip-select released
            div_d = div_end ? '0 : div_q + DIV_W'(1);
            sck_d = 1'b0;
            if (div_end) xdcs_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign fifo_rd_en = state_q == RD;
   assign busy       = state_q != IDLE;
   assign sck        = sck_q;
   assign sdi        = sdi_q;
   assign xdcs       = xdcs_q;
endmodule

// File: tb/tb_fifo_spi_drain.sv
// tb_fifo_spi_drain: scoreboard bench for fifo_spi_drain with a queue-based FIFO model and SPI monitor.
module tb_fifo_spi_drain;
   localparam int DW = 8;
   localparam int CD = 4;
   localparam int BL = 32;

   logic          clk = 0, rst = 1, enable = 0, fifo_empty = 1, dreq = 0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd_en, sck, sdi, xdcs, busy;

   fifo_spi_drain #(.DATA_WIDTH(DW), .CLK_DIV(CD), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .dreq(dreq), .sck(sck), .sdi(sdi), .xdcs(xdcs), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   function automatic void chk(input bit ok, input string nm, input int act, input int req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
   endfunction

   logic [DW-1:0] fq[$], exp_q[$];
   int            win_q[$];
   int            pops = 0;

   // sync FIFO model: data_out registered one cycle after the pop strobe
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         pops++;
         if (fq.size() != 0) begin
            fifo_empty <= (fq.size() == 1);
            fifo_data  <= fq.pop_front();
         end
      end
   end

   task automatic push(input logic [DW-1:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
      fifo_empty = 0;
   endtask

   function automatic int pop_win();
      if (win_q.size() == 0) return -1;
      return win_q.pop_front();
   endfunction

   logic          sck_p = 0, xdcs_p = 1;
   int            hold = 0, xlow = 0, sfall = 0, nbits = 0, win = 0;
   logic [DW-1:0] acc = '0, e;

   always @(negedge clk) begin
      if (rst) begin
         sck_p = 0; xdcs_p = 1; hold = 0; xlow = 0; sfall = 0; nbits = 0; win = 0;
      end else begin
         if (fifo_rd_en) chk(!fifo_empty, "rd_while_empty", int'(fifo_empty), 0);
         if (xdcs && !xdcs_p) begin
            chk(nbits == 0, "xdcs_partial", nbits, 0);
            chk(sfall == CD, "xdcs_rise_delay", sfall, CD);
            chk(win >= 1 && win <= BL, "burst_len", win, BL);
            win_q.push_back(win);
            win = 0;
         end
         if (sck && !sck_p) begin
            chk(!xdcs, "xdcs_low_on_rise", int'(xdcs), 0);
            if (nbits == 0) begin
               if (win == 0) chk(xlow >= CD, "xdcs_setup", xlow, CD);
               else chk(hold == CD + 2, "frame_gap", hold, CD + 2);
            end else chk(hold == CD, "sck_low", hold, CD);
            acc = {acc[DW-2:0], sdi};
            nbits++;
            hold = 1;
         end else if (!sck && sck_p) begin
            chk(hold == CD, "sck_high", hold, CD);
            hold = 1;
            sfall = 1;
            if (nbits == DW) begin
               if (exp_q.size() == 0) chk(0, "unexpected_frame", int'(acc), -1);
               else begin
                  e = exp_q.pop_front();
                  chk(acc == e, "frame_data", int'(acc), int'(e));
               end
               nbits = 0;
               win++;
            end
         end else begin
            hold++;
            sfall++;
         end
         if (!xdcs && xdcs_p) xlow = 1; else xlow++;
         sck_p = sck;
         xdcs_p = xdcs;
      end
   end

   task automatic wait_drain(input int lim);
      int t = 0;
      while ((fq.size() != 0 || exp_q.size() != 0 || busy) && t < lim) begin
         @(negedge clk);
         t++;
      end
      chk(t < lim, "drain_timeout", t, lim);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string nm);
      chk(xdcs == 1 && sck == 0 && sdi == 0 && fifo_rd_en == 0 && busy == 0, nm,
          int'({xdcs, sck, sdi, fifo_rd_en, busy}), 5'b10000);
   endtask

   initial begin
      int t, p0, n;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_state");
      rst = 0;
      enable = 1;

      // reset in the middle of a frame
      push(DW'($urandom));
      dreq = 1;
      t = 0;
      while (nbits < 2 && t < 500) begin @(negedge clk); t++; end
      chk(t < 500, "reset_wait_timeout", t, 500);
      #1 rst = 1;
      #1 check_idle_outputs("reset_mid_shift");
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 0;
      p0 = pops;
      repeat (20) @(negedge clk);
      chk(pops == p0, "no_pop_after_reset", pops - p0, 0);
      chk(!busy, "idle_after_reset", int'(busy), 0);

      // single byte
      win_q.delete();
      p0 = pops;
      push(8'hA5);
      wait_drain(2000);
      chk(pops - p0 == 1, "single_pops", pops - p0, 1);
      chk(pop_win() == 1, "single_window", win_q.size(), 1);

      // burst limit: 40 bytes split 32 + 8
      win_q.delete();
      for (int i = 0; i < 40; i++) push(DW'(i));
      wait_drain(20000);
      chk(pop_win() == BL, "burst_first", win, BL);
      chk(pop_win() == 8, "burst_second", win, 8);
      chk(win_q.size() == 0, "burst_count", win_q.size(), 0);

      // empty mid-burst, with dreq dropped after the first pop
      win_q.delete();
      p0 = pops;
      for (int i = 0; i < 3; i++) push(DW'($urandom));
      t = 0;
      while (pops == p0 && t < 100) begin @(negedge clk); t++; end
      dreq = 0;
      wait_drain(2000);
      chk(pop_win() == 3, "empty_window", pops - p0, 3);
      repeat (20) @(negedge clk);
      dreq = 1;
      push(DW'($urandom));
      wait_drain(2000);
      chk(pop_win() == 1, "refill_window", pops - p0, 4);

      // dreq gating
      win_q.delete();
      dreq = 0;
      repeat (10) @(negedge clk);
      p0 = pops;
      push(DW'($urandom));
      push(DW'($urandom));
      repeat (20) @(negedge clk);
      chk(pops == p0, "dreq_low_no_pop", pops - p0, 0);
      chk(!busy, "dreq_low_idle", int'(busy), 0);
      dreq = 1;
      t = 0;
      while (!fifo_rd_en && t < 10) begin @(negedge clk); t++; end
      chk(t <= 3, "dreq_latency", t, 3);
      wait_drain(2000);
      chk(pop_win() == 2, "dreq_window", pops - p0, 2);

      // enable dropped during frame 2
      win_q.delete();
      p0 = pops;
      for (int i = 0; i < 5; i++) push(DW'($urandom));
      t = 0;
      while (pops - p0 < 2 && t < 500) begin @(negedge clk); t++; end
      repeat (10) @(negedge clk);
      enable = 0;
      t = 0;
      while (busy && t < 500) begin @(negedge clk); t++; end
      repeat (20) @(negedge clk);
      chk(pops - p0 == 2, "enable_drop_pops", pops - p0, 2);
      chk(pop_win() == 2, "enable_drop_window", win_q.size(), 1);
      chk(exp_q.size() == 3, "enable_drop_left", exp_q.size(), 3);
      enable = 1;
      wait_drain(2000);
      chk(pop_win() == 3, "enable_resume_window", pops - p0, 5);

      // randomized traffic with random dreq stalls
      for (int k = 0; k < 6; k++) begin
         dreq = 1'($urandom);
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) push(DW'($urandom));
         repeat ($urandom_range(0, 30)) @(negedge clk);
         dreq = 1;
         wait_drain(5000);
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fifo_spi_drain.md
Name: fifo_spi_drain

Overview:
Reader-side consumer for the audio byte FIFO. It pops bytes from the FIFO and serialises them MSB-first over an SPI-style data port (SCK/SDI/xDCS) to the external MP3 decoder's serial data input. Transfers are gated by the decoder's DREQ flow-control line and issued in bursts of up to BURST_LEN bytes. It sits between the sync FIFO (data_out registered one cycle after rd_en) and the decoder pins.

Parameters:
DATA_WIDTH, 8, bits per FIFO word / SPI frame, shifted MSB first.
CLK_DIV, 4, clk cycles per SCK half-period (>=1); one frame = 2*CLK_DIV*DATA_WIDTH cycles.
BURST_LEN, 32, maximum frames per DREQ grant (>=1).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  permit new bursts/frames
fifo_empty  in  1  FIFO empty flag
fifo_data  in  DATA_WIDTH  FIFO data_out, valid the cycle after fifo_rd_en
fifo_rd_en  out  1  single-cycle FIFO pop strobe
dreq  in  1  decoder ready (asynchronous to clk)
sck  out  1  serial clock, idle low (mode 0)
sdi  out  1  serial data
xdcs  out  1  data chip-select, active low
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async): fifo_rd_en=0, sck=0, sdi=0, xdcs=1, busy=0, state=IDLE, shift register, bit counter, divider and burst counter cleared. Reset mid-frame aborts immediately; the partial frame is lost and the popped byte is not re-read.
- dreq passes through a 2-flop synchroniser; only the synchronised value (dreq_s) is used. dreq_s is sampled only in IDLE; deassertion mid-burst is ignored (decoder guarantees BURST_LEN bytes per grant).
- States: IDLE, RD, LOAD, SHIFT, GAP.
- IDLE: if enable && dreq_s && !fifo_empty -> RD, burst_cnt=0.
- RD (1 cycle): fifo_rd_en=1 -> LOAD. fifo_rd_en is high only in RD and is never asserted while fifo_empty=1.
- LOAD (1 cycle): shift register <= fifo_data; xdcs<=0; sdi<=MSB; -> SHIFT. xdcs falls at least CLK_DIV cycles before the first SCK rise.
- SHIFT: divider counts CLK_DIV cycles per half-period. Low phase ends -> sck<=1 (decoder samples). High phase ends -> sck<=0, shift left, sdi<=next bit, bit_cnt++. After the DATA_WIDTH-th falling edge, the frame is done and burst_cnt++.
- Frame done: if burst_cnt<BURST_LEN && enable && !fifo_empty -> RD, with xdcs held low (back-to-back frames, 2-cycle RD/LOAD gap with sck low). Otherwise -> GAP.
- GAP: xdcs=1, sck=0, held CLK_DIV cycles -> IDLE, which re-evaluates dreq_s.
- enable deasserted mid-frame: the current frame completes, then GAP. fifo_empty rising mid-burst: the burst ends at the frame boundary (GAP).
- burst_cnt width is clog2(BURST_LEN+1). Divider and bit counters wrap to 0 at each phase/frame boundary.
- Throughput: at most one byte per 2*CLK_DIV*DATA_WIDTH+2 cycles.

Test Plan:
- Reset: assert rst mid-SHIFT -> outputs immediately xdcs=1, sck=0, sdi=0, fifo_rd_en=0, busy=0. No further pops after release until conditions are met.
- Single byte: FIFO holds 0xA5, dreq=1, enable=1, CLK_DIV=4 -> one fifo_rd_en pulse; SDI sampled on 8 SCK rises = 1,0,1,0,0,1,0,1; SCK high/low 4 cycles each; xdcs returns high 4 cycles after the last fall.
- Burst limit: FIFO holds 40 bytes 0x00..0x27, dreq held 1 -> first burst of 32 frames (0x00..0x1F) under one xdcs low window, then a GAP, then the remaining 8 bytes in a new burst. No byte is lost or duplicated.
- Empty mid-burst: 3 bytes in FIFO -> 3 frames, then GAP/IDLE. fifo_rd_en never high while fifo_empty=1. Writing a 4th byte later starts a new burst.
- DREQ gating: dreq=0 with a non-empty FIFO -> no pop, busy=0. dreq rises -> fifo_rd_en within 3 cycles. dreq dropped mid-burst -> the burst still completes.
- Enable drop: deassert enable during frame 2 -> frame 2 completes all 8 bits, xdcs rises, and no third pop occurs.
